// File: rtl/umi_to_axi_wr.sv
// UMI write packets become single-beat AXI4 writes; one transaction in flight at a time.
// Packet layout: opcode = packet[7:0], dstaddr = {packet[255:224], packet[63:32]}, data = whole packet.
module umi_to_axi_wr #(
  parameter logic [7:0] WRITE_OPCODE = 8'd0,
  parameter int         CNTW         = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [255:0]    umi_packet,
  input  logic            umi_valid,
  output logic            umi_ready,
  output logic            axi_awvalid,
  input  logic            axi_awready,
  output logic [63:0]     axi_awaddr,
  output logic [7:0]      axi_awlen,
  output logic [2:0]      axi_awsize,
  output logic [1:0]      axi_awburst,
  output logic            axi_wvalid,
  input  logic            axi_wready,
  output logic [255:0]    axi_wdata,
  output logic [31:0]     axi_wstrb,
  output logic            axi_wlast,
  input  logic            axi_bvalid,
  output logic            axi_bready,
  input  logic [1:0]      axi_bresp,
  output logic [CNTW-1:0] err_count,
  output logic [CNTW-1:0] drop_count
);

  typedef enum logic [1:0] {IDLE, SEND, RESP} state_t;

  state_t         state;
  logic           aw_done;
  logic           w_done;
  logic [7:0]     pkt_opcode;
  logic [63:0]    pkt_dstaddr;
  logic [255:0]   pkt_data;
  logic           aw_hs;
  logic           w_hs;
  logic           aw_done_nxt;
  logic           w_done_nxt;

  function automatic void umi_unpack(input  logic [255:0] p,
                                     output logic [7:0]   opcode,
                                     output logic [63:0]  dstaddr,
                                     output logic [255:0] data);
    opcode  = p[7:0];
    dstaddr = {p[255:224], p[63:32]};
    data    = p;
  endfunction

  function automatic logic [CNTW-1:0] sat_inc(input logic [CNTW-1:0] c);
    return (&c) ? c : c + {{(CNTW-1){1'b0}}, 1'b1};
  endfunction

  always_comb begin
    pkt_opcode  = '0;
    pkt_dstaddr = '0;
    pkt_data    = '0;
    umi_unpack(umi_packet, pkt_opcode, pkt_dstaddr, pkt_data);
  end

  assign umi_ready   = (state == IDLE) && !rst;
  assign aw_hs       = axi_awvalid && axi_awready;
  assign w_hs        = axi_wvalid && axi_wready;
  assign aw_done_nxt = aw_done || aw_hs;
  assign w_done_nxt  = w_done || w_hs;

  assign axi_awlen   = 8'd0;
  assign axi_awsize  = 3'd5;
  assign axi_awburst = 2'b01;
  assign axi_wstrb   = '1;
  assign axi_wlast   = 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      axi_awvalid <= 1'b0;
      axi_wvalid  <= 1'b0;
      axi_bready  <= 1'b0;
      axi_awaddr  <= '0;
      axi_wdata   <= '0;
      aw_done     <= 1'b0;
      w_done      <= 1'b0;
      err_count   <= '0;
      drop_count  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (umi_valid) begin
            if (pkt_opcode == WRITE_OPCODE) begin
              axi_awaddr  <= pkt_dstaddr;
              axi_wdata   <= pkt_data;
              aw_done     <= 1'b0;
              w_done      <= 1'b0;
              axi_awvalid <= 1'b1;
              axi_wvalid  <= 1'b1;
              state       <= SEND;
            end else begin
              drop_count <= sat_inc(drop_count);
            end
          end
        end
        SEND: begin
          // Each channel retires independently; RESP waits for both, even if they finish together.
          aw_done     <= aw_done_nxt;
          w_done      <= w_done_nxt;
          axi_awvalid <= !aw_done_nxt;
          axi_wvalid  <= !w_done_nxt;
          if (aw_done_nxt && w_done_nxt) begin
            axi_bready <= 1'b1;
            state      <= RESP;
          end
        end
        RESP: begin
          if (axi_bvalid) begin
            if (axi_bresp != 2'b00) err_count <= sat_inc(err_count);
            axi_bready <= 1'b0;
            state      <= IDLE;
          end
        end
        default: begin
          axi_awvalid <= 1'b0;
          axi_wvalid  <= 1'b0;
          axi_bready  <= 1'b0;
          state       <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/umi_to_axi_wr.md
Name: umi_to_axi_wr

Overview:
- Converts inbound UMI write packets into single-beat AXI4 write transactions, acting as the AXI write master.
- Sits at the UMI-to-memory-fabric boundary of the riscv-grid example and drives an AXI slave such as a memory model or a peripheral.
- Accepts one packet at a time. It issues AW and W independently, waits for B, and only then accepts the next packet.
- Counts error responses and counts non-write packets that it discards.

Parameters:
- WRITE_OPCODE, 8'd0: UMI opcode treated as a write; packets with any other opcode are discarded.
- CNTW, 16: width of the saturating status counters.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- umi_packet  in  256  inbound UMI packet; fields extracted with umi_unpack (opcode, dstaddr, data)
- umi_valid  in  1  packet valid
- umi_ready  out  1  packet accepted when umi_valid & umi_ready
- axi_awvalid  out  1  write address valid
- axi_awready  in  1  write address ready
- axi_awaddr  out  64  write address = captured dstaddr
- axi_awlen  out  8  constant 0
- axi_awsize  out  3  constant 3'd5 (32 bytes)
- axi_awburst  out  2  constant 2'b01 (INCR)
- axi_wvalid  out  1  write data valid
- axi_wready  in  1  write data ready
- axi_wdata  out  256  captured data
- axi_wstrb  out  32  constant all ones
- axi_wlast  out  1  constant 1
- axi_bvalid  in  1  write response valid
- axi_bready  out  1  write response ready
- axi_bresp  in  2  write response code
- err_count  out  CNTW  number of B responses with bresp != 2'b00; saturates
- drop_count  out  CNTW  number of discarded non-write packets; saturates

Behaviour:
- Reset values:
  - State is IDLE.
  - umi_ready is 1.
  - axi_awvalid, axi_wvalid and axi_bready are 0.
  - axi_awaddr and axi_wdata are 0.
  - err_count and drop_count are 0.
  - aw_done and w_done are 0.
- umi_ready is combinational: it is 1 exactly when the state is IDLE and rst is low.
- IDLE, handshake in cycle N:
  - If opcode == WRITE_OPCODE: register dstaddr and data, clear aw_done and w_done, and go to SEND. axi_awvalid and axi_wvalid are high from cycle N+1.
  - Otherwise: increment drop_count (saturating) and stay in IDLE. umi_ready stays 1.
- SEND:
  - axi_awvalid = ~aw_done and axi_wvalid = ~w_done. Both are registered outputs.
  - On an awvalid & awready cycle: set aw_done and deassert awvalid on the next cycle.
  - On a wvalid & wready cycle: set w_done and deassert wvalid on the next cycle.
  - The AW and W handshakes may occur in the same cycle or in either order, with any number of wait cycles.
  - Address and data stay stable while their valid is high.
  - When both handshakes are complete, including the case where both complete in the same cycle, go to RESP on the next cycle.
- RESP:
  - axi_bready = 1.
  - On a bvalid & bready cycle: if bresp != 2'b00, increment err_count (saturating). Then go to IDLE; umi_ready is 1 in the next cycle.
  - bready is 0 in every other state, so a bvalid that arrives early is held off by the slave's protocol.
- Minimum latency:
  - Accept at cycle N, AW/W handshake at N+1, bready high at N+2, B handshake at N+2, umi_ready high at N+3.
  - Peak throughput is one write per 3 cycles.
- Counters: when a counter is at 2^CNTW-1, an increment leaves it unchanged.
- Reset mid-operation:
  - From any state, go to IDLE and drop all valids and bready within the same clock edge.
  - The in-flight transaction is abandoned, with no retry.
  - Counters clear.
- All AXI outputs other than the valids and bready are driven from registers or constants; there is no combinational path from UMI inputs to AXI outputs.

Test Plan:
- Write packet dstaddr=0x1000, data=0xAA..AA, with awready=wready=1 and bvalid returned 1 cycle after bready → awaddr=0x1000, wdata=0xAA..AA, wstrb=0xFFFFFFFF, umi_ready low for exactly 3 cycles.
- awready held low 5 cycles while wready=1 → W handshake at N+1, AW handshake at N+6, each valid asserted until its own handshake, no duplicate handshakes, then RESP.
- Packet with opcode=8'd1 → no AXI activity, drop_count=1, umi_ready stays 1; a following write packet is handled normally.
- bresp=2'b10 on first write and 2'b00 on second → err_count=1 after both complete.
- rst asserted in RESP with bvalid low → next cycle state is IDLE, bready=0, umi_ready=1, counters=0; the next packet completes normally.
- CNTW=2, five bad-opcode packets → drop_count saturates at 3.
